mu0_memory_system: RTL and testbench
====================================

// Module: mu0_memory_system
// PURPOSE
//  Word-addressed memory system directly downstream of the MU0 CPU: consumes Addr/Rd/Wr/Data_out
//  and returns Data_in. Maps 0x000-0xFEF to a program/data RAM and 0xFF0-0xFFF to I/O registers:
//  output port, synchronised input port and an optional 16-bit interval timer.
//  Combinational read; all state changes on Clk rising edge.
// PARAMETERS
//  INIT_FILE   "mu0_prog.hex"  hex image loaded into RAM by $readmemh at time 0 ("" = no load)
//  IO_BASE     12'hFF0         first I/O address; RAM occupies 0x000..IO_BASE-1
// PORTS
//  Clk       in   1   system clock, rising edge
//  Reset     in   1   synchronous, active-high reset
//  Rd        in   1   CPU read strobe
//  Wr        in   1   CPU write strobe
//  Addr      in   12  CPU word address
//  Wr_data   in   16  write data (CPU Data_out)
//  Rd_data   out  16  read data (CPU Data_in)
//  Halted    in   1   CPU halted; freezes timer
//  Port_in   in   16  external asynchronous input pins
//  Port_out  out  16  output port register
//  Timer_irq out  1   timer overflow flag (level)
// BEHAVIOUR
//  - Read: Rd_data = selected word, same cycle (combinational) when Rd=1; Rd_data=16'h0000 when Rd=0.
//  - Write: Wr=1 updates target on the next rising edge. Rd=1 and Wr=1 together: write performed,
//    Rd_data shows the pre-write value.
//  - RAM is not cleared by Reset; contents persist across reset, initialised only by INIT_FILE.
//  - I/O map (offset from IO_BASE):
//    +0 OUT    RW  Port_out register; reset 0x0000
//    +1 IN     RO  Port_in through 2-flop synchroniser (2-cycle latency); synchroniser resets to 0
//    +2 TCNT   RW  timer count; reset 0x0000
//    +3 TCTRL  RW  bit0 EN, bit1 AUTO_RELOAD, bit15 OVF (sticky, write-1-to-clear); other bits read 0;
//                  reset 0x0000
//    +4 TRELOAD RW reload value; reset 0x0000
//    +5..+15   read 0x0000, writes ignored
//  - Timer: TCNT += 1 per cycle when EN=1 and Halted=0. At TCNT=0xFFFF the next tick sets OVF and
//    loads TRELOAD if AUTO_RELOAD=1, else wraps to 0x0000 and clears EN.
//  - Simultaneous events: CPU write to TCNT beats tick in that cycle; write of 1 to OVF beats a
//    set in the same cycle (flag cleared); write to TCTRL EN/AUTO takes effect from the next cycle.
//  - Timer_irq = OVF. Reset mid-count returns TCNT, TCTRL, TRELOAD, Port_out, Timer_irq to 0.
//  - Addresses >= IO_BASE never reach RAM; RAM write with Addr>=IO_BASE impossible.
// CONFIGURATION
//  MU0_TIMER_EN defined: timer registers +2..+4 and Timer_irq behave as above.
//  MU0_TIMER_EN undefined: no timer logic instantiated; +2..+4 read 0x0000, writes ignored,
//  Timer_irq tied to 0.
// TESTING
//  1 INIT_FILE word0=0x1FF1; Reset 1 cycle, Rd=1 Addr=0x000 -> Rd_data=0x1FF1 same cycle; Rd=0 -> 0x0000.
//  2 Wr=1 Addr=0x123 Wr_data=0xBEEF, then Rd Addr=0x123 -> 0xBEEF; Reset; reread -> still 0xBEEF.
//  3 Wr 0xA5A5 to 0xFF0 -> Port_out=0xA5A5 next edge; Reset -> 0x0000; Port_in=0x1234 ->
//    read 0xFF1 = 0x1234 after 2 edges, not after 1.
//  4 (timer) TRELOAD=0xFFFE, TCNT=0xFFFE, TCTRL=0x0003: 2 ticks -> OVF=1, Timer_irq=1, TCNT=0xFFFE;
//    Halted=1 for 5 cycles -> TCNT unchanged; write TCTRL=0x8003 -> OVF=0, timer continues.
//  5 (timer) TCNT=0xFFFF, TCTRL=0x0001 -> next edge TCNT=0x0000, EN=0, OVF=1; write TCNT=0x0100
//    with EN=1 in same cycle as tick -> TCNT=0x0100.
//  6 Build without MU0_TIMER_EN: write 0xFF2..0xFF4 with 0xFFFF -> all read 0x0000, Timer_irq=0;
//    read 0xFF7 -> 0x0000 in both builds.

Source files
------------

// File: rtl/mu0_memory_system_if.sv
// CPU-side bus of the MU0 memory system: read/write strobes, word address and data.
// master = MU0 CPU, slave = memory system.
interface mu0_memory_system_if;
  logic        Rd;
  logic        Wr;
  logic [11:0] Addr;
  logic [15:0] Wr_data;
  logic [15:0] Rd_data;

  modport master (output Rd, Wr, Addr, Wr_data, input Rd_data);
  modport slave  (input Rd, Wr, Addr, Wr_data, output Rd_data);
endinterface

// File: rtl/mu0_memory_system.sv
// MU0 memory system: program/data RAM below IO_BASE, I/O registers (output port,
// synchronised input port, optional interval timer enabled by `define MU0_TIMER_EN) above it.
module mu0_memory_system #(
  parameter              INIT_FILE = "mu0_prog.hex",
  parameter logic [11:0] IO_BASE   = 12'hFF0
) (
  input  logic                       Clk,
  input  logic                       Reset,
  mu0_memory_system_if.slave         bus,
  input  logic                       Halted,
  input  logic [15:0]                Port_in,
  output logic [15:0]                Port_out,
  output logic                       Timer_irq
);

  localparam int          RAM_WORDS = int'(IO_BASE);
  localparam logic [11:0] OFF_OUT   = 12'd0;
  localparam logic [11:0] OFF_IN    = 12'd1;
  localparam logic [11:0] OFF_TCNT  = 12'd2;
  localparam logic [11:0] OFF_TCTRL = 12'd3;
  localparam logic [11:0] OFF_TRLD  = 12'd4;

  logic [15:0] ram [RAM_WORDS];
  logic        is_io;
  logic        wr_io;
  logic [11:0] io_off;
  logic [15:0] sync_meta;
  logic [15:0] sync_in;
  logic [15:0] rd_word;

  assign is_io  = (bus.Addr >= IO_BASE);
  assign io_off = bus.Addr - IO_BASE;
  assign wr_io  = bus.Wr && is_io;

  // NOTE: the RAM has no reset branch; program contents must survive Reset and a
  // reset term would also stop the array mapping onto a block RAM.
  always_ff @(posedge Clk) begin
    if (bus.Wr && !is_io) ram[bus.Addr] <= bus.Wr_data;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      Port_out  <= '0;
      sync_meta <= '0;
      sync_in   <= '0;
    end else begin
      sync_meta <= Port_in;
      sync_in   <= sync_meta;
      if (wr_io && io_off == OFF_OUT) Port_out <= bus.Wr_data;
    end
  end

`ifdef MU0_TIMER_EN
  logic [15:0] tcnt;
  logic [15:0] treload;
  logic        t_en;
  logic        t_auto;
  logic        t_ovf;
  logic        tick;
  logic        wrap;

  assign tick = t_en && !Halted;
  assign wrap = tick && (tcnt == 16'hFFFF);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      tcnt    <= '0;
      treload <= '0;
      t_en    <= 1'b0;
      t_auto  <= 1'b0;
      t_ovf   <= 1'b0;
    end else begin
      if (wrap) begin
        t_ovf <= 1'b1;
        if (t_auto) begin
          tcnt <= treload;
        end else begin
          tcnt <= '0;
          t_en <= 1'b0;
        end
      end else if (tick) begin
        tcnt <= tcnt + 16'd1;
      end
      // NOTE: the last non-blocking assignment to a register in a clock edge wins, so
      // placing CPU writes after the tick logic gives them priority over the timer.
      if (wr_io && io_off == OFF_TCNT) tcnt <= bus.Wr_data;
      if (wr_io && io_off == OFF_TCTRL) begin
        t_en   <= bus.Wr_data[0];
        t_auto <= bus.Wr_data[1];
        if (bus.Wr_data[15]) t_ovf <= 1'b0;
      end
      if (wr_io && io_off == OFF_TRLD) treload <= bus.Wr_data;
    end
  end

  assign Timer_irq = t_ovf;
`else
  logic unused_halted;
  assign unused_halted = Halted;
  assign Timer_irq     = 1'b0;
`endif

  // NOTE: rd_word gets a default before the decode so no path through the block
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    rd_word = '0;
    if (!is_io) begin
      rd_word = ram[bus.Addr];
    end else begin
      case (io_off)
        OFF_OUT:   rd_word = Port_out;
        OFF_IN:    rd_word = sync_in;
`ifdef MU0_TIMER_EN
        OFF_TCNT:  rd_word = tcnt;
        OFF_TCTRL: rd_word = {t_ovf, 13'h0000, t_auto, t_en};
        OFF_TRLD:  rd_word = treload;
`endif
        default:   rd_word = '0;
      endcase
    end
  end

  // Reads return the pre-write value when Rd and Wr coincide, since RAM and registers
  // only change on the following edge.
  assign bus.Rd_data = bus.Rd ? rd_word : 16'h0000;

endmodule

// File: tb/tb_mu0_memory_system.sv
// Self-checking bench for mu0_memory_system: directed scenarios then randomized bus
// traffic, all compared against a behavioural model of the memory map.
module tb_mu0_memory_system;

  logic        clk = 1'b0;
  logic        reset;
  logic        halted;
  logic [15:0] port_in;
  logic [15:0] port_out;
  logic        timer_irq;

  mu0_memory_system_if bus();

  mu0_memory_system #(.INIT_FILE(""), .IO_BASE(12'hFF0)) dut (
    .Clk       (clk),
    .Reset     (reset),
    .bus       (bus),
    .Halted    (halted),
    .Port_in   (port_in),
    .Port_out  (port_out),
    .Timer_irq (timer_irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model of the visible memory map.
  logic [15:0] m_ram [int];
  logic [15:0] m_pins [$];
  logic [15:0] m_out;
  logic [15:0] m_cnt;
  logic [15:0] m_reload;
  logic        m_en;
  logic        m_auto;
  logic        m_ovf;
  logic [15:0] last_rd;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model_read(input logic [11:0] a);
    int off;
    off = int'(a) - 'hFF0;
    if (off < 0) return m_ram.exists(int'(a)) ? m_ram[int'(a)] : 16'h0000;
    case (off)
      0: return m_out;
      1: return m_pins[0];
`ifdef MU0_TIMER_EN
      2: return m_cnt;
      3: return {m_ovf, 13'h0000, m_auto, m_en};
      4: return m_reload;
`endif
      default: return 16'h0000;
    endcase
  endfunction

  task automatic model_edge(input logic rst, input logic wr, input logic [11:0] a,
                            input logic [15:0] d, input logic hlt, input logic [15:0] pin);
    logic [15:0] n_cnt;
    logic        n_en;
    logic        n_ovf;
    if (rst) begin
      m_out = 16'h0; m_cnt = 16'h0; m_reload = 16'h0;
      m_en = 1'b0; m_auto = 1'b0; m_ovf = 1'b0;
      m_pins = {16'h0000, 16'h0000};
      return;
    end
    // Input port shows the pin value sampled two edges back.
    m_pins.push_back(pin);
    void'(m_pins.pop_front());
    n_cnt = m_cnt; n_en = m_en; n_ovf = m_ovf;
`ifdef MU0_TIMER_EN
    if (m_en && !hlt) begin
      if (m_cnt == 16'hFFFF) begin
        n_ovf = 1'b1;
        if (m_auto) n_cnt = m_reload;
        else begin n_cnt = 16'h0000; n_en = 1'b0; end
      end else begin
        n_cnt = 16'((int'(m_cnt) + 1) % 65536);
      end
    end
`endif
    if (wr) begin
      if (a < 12'hFF0) m_ram[int'(a)] = d;
      else begin
        case (a)
          12'hFF0: m_out = d;
`ifdef MU0_TIMER_EN
          12'hFF2: n_cnt = d;
          12'hFF3: begin n_en = d[0]; m_auto = d[1]; if (d[15]) n_ovf = 1'b0; end
          12'hFF4: m_reload = d;
`endif
          default: ;
        endcase
      end
    end
    m_cnt = n_cnt; m_en = n_en; m_ovf = n_ovf;
  endtask

  // One bus cycle: drive, check the combinational read, clock, check the outputs.
  task automatic cycle(input logic rd, input logic wr, input logic [11:0] a,
                       input logic [15:0] d, input logic hlt, input logic rst);
    bus.Rd = rd; bus.Wr = wr; bus.Addr = a; bus.Wr_data = d;
    halted = hlt; reset = rst;
    #2;
    last_rd = bus.Rd_data;
    if (!rd) check("rd_idle", bus.Rd_data, 16'h0000);
    else if (a >= 12'hFF0 || m_ram.exists(int'(a)))
      check($sformatf("rd_%h", a), bus.Rd_data, model_read(a));
    @(posedge clk);
    model_edge(rst, wr, a, d, hlt, port_in);
    #1;
    check("port_out", port_out, m_out);
    check("timer_irq", {15'h0000, timer_irq}, {15'h0000, m_ovf});
  endtask

  task automatic wr_word(input logic [11:0] a, input logic [15:0] d);
    cycle(1'b0, 1'b1, a, d, 1'b0, 1'b0);
  endtask

  task automatic rd_word(input logic [11:0] a, input logic hlt);
    cycle(1'b1, 1'b0, a, 16'h0000, hlt, 1'b0);
  endtask

  task automatic do_reset();
    cycle(1'b0, 1'b0, 12'h000, 16'h0000, 1'b0, 1'b1);
  endtask

  initial begin
    logic [11:0] a;
    logic [15:0] d;
    logic        rst, wr, rd, hlt;
    port_in = 16'h0000;
    m_pins  = {16'h0000, 16'h0000};
    m_out = 16'h0; m_cnt = 16'h0; m_reload = 16'h0;
    m_en = 1'b0; m_auto = 1'b0; m_ovf = 1'b0;

    do_reset();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      rd_word(12'hFF0 + 12'(i), 1'b0);
      check($sformatf("rst_io_%0d", i), last_rd, 16'h0000);
    end

    // Word 0 load, combinational read, Rd=0 returns zero
    wr_word(12'h000, 16'h1FF1);
    rd_word(12'h000, 1'b0);
    check("word0", last_rd, 16'h1FF1);
    cycle(1'b0, 1'b0, 12'h000, 16'h0000, 1'b0, 1'b0);

    // RAM survives reset; read during write shows the old value
    wr_word(12'h123, 16'hBEEF);
    rd_word(12'h123, 1'b0);
    do_reset();
    rd_word(12'h123, 1'b0);
    check("ram_after_reset", last_rd, 16'hBEEF);
    cycle(1'b1, 1'b1, 12'h123, 16'h5555, 1'b0, 1'b0);
    check("rw_prewrite", last_rd, 16'hBEEF);
    rd_word(12'h123, 1'b0);
    check("rw_postwrite", last_rd, 16'h5555);

    // Top RAM word and an unmapped I/O slot
    wr_word(12'hFEF, 16'h0F0F);
    wr_word(12'hFF5, 16'hFFFF);
    rd_word(12'hFF5, 1'b0);
    check("unmapped_ff5", last_rd, 16'h0000);
    rd_word(12'hFEF, 1'b0);
    check("ram_top", last_rd, 16'h0F0F);

    // Output port and input synchroniser latency
    wr_word(12'hFF0, 16'hA5A5);
    check("out_written", port_out, 16'hA5A5);
    do_reset();
    check("out_reset", port_out, 16'h0000);
    port_in = 16'h1234;
    rd_word(12'hFF1, 1'b0);
    rd_word(12'hFF1, 1'b0);
    check("in_after_1_edge", last_rd, 16'h0000);
    rd_word(12'hFF1, 1'b0);
    check("in_after_2_edges", last_rd, 16'h1234);

`ifdef MU0_TIMER_EN
    // Auto-reload overflow, halt freeze, write-1-to-clear
    wr_word(12'hFF4, 16'hFFFE);
    wr_word(12'hFF2, 16'hFFFE);
    wr_word(12'hFF3, 16'h0003);
    cycle(1'b0, 1'b0, 12'h000, 16'h0000, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 12'h000, 16'h0000, 1'b0, 1'b0);
    check("t4_irq", {15'h0000, timer_irq}, 16'h0001);
    for (int i = 0; i < 5; i++) begin
      rd_word(12'hFF2, 1'b1);
      check("t4_halted_cnt", last_rd, 16'hFFFE);
    end
    rd_word(12'hFF3, 1'b1);
    check("t4_ctrl_ovf", last_rd, 16'h8003);
    wr_word(12'hFF3, 16'h8003);
    check("t4_irq_cleared", {15'h0000, timer_irq}, 16'h0000);
    rd_word(12'hFF2, 1'b0);
    check("t4_continues", last_rd, 16'hFFFF);

    // One-shot wrap clears EN; CPU write to TCNT beats the tick
    wr_word(12'hFF3, 16'h0000);
    wr_word(12'hFF2, 16'hFFFF);
    wr_word(12'hFF3, 16'h0001);
    cycle(1'b0, 1'b0, 12'h000, 16'h0000, 1'b0, 1'b0);
    rd_word(12'hFF3, 1'b0);
    check("t5_ctrl", last_rd, 16'h8000);
    rd_word(12'hFF2, 1'b0);
    check("t5_cnt_wrap", last_rd, 16'h0000);
    wr_word(12'hFF3, 16'h0001);
    wr_word(12'hFF2, 16'h0100);
    rd_word(12'hFF2, 1'b1);
    check("t5_write_beats_tick", last_rd, 16'h0100);

    // Clear beats a set in the same cycle
    wr_word(12'hFF2, 16'hFFFF);
    wr_word(12'hFF3, 16'h8003);
    rd_word(12'hFF3, 1'b1);
    check("clear_beats_set", last_rd, 16'h0003);

    // Reset mid-count
    do_reset();
    rd_word(12'hFF2, 1'b0);
    check("t_reset_cnt", last_rd, 16'h0000);
    rd_word(12'hFF3, 1'b0);
    check("t_reset_ctrl", last_rd, 16'h0000);
`else
    for (int i = 2; i <= 4; i++) begin
      wr_word(12'hFF0 + 12'(i), 16'hFFFF);
      rd_word(12'hFF0 + 12'(i), 1'b0);
      check($sformatf("no_timer_%0d", i), last_rd, 16'h0000);
    end
    check("no_timer_irq", {15'h0000, timer_irq}, 16'h0000);
`endif
    wr_word(12'hFF7, 16'hFFFF);
    rd_word(12'hFF7, 1'b0);
    check("unmapped_ff7", last_rd, 16'h0000);

    // Randomized traffic over low RAM, top RAM and the whole I/O window
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 99) < 2);
      case ($urandom_range(0, 2))
        0:       a = 12'h000 + 12'($urandom_range(0, 15));
        1:       a = 12'hFE0 + 12'($urandom_range(0, 15));
        default: a = 12'hFF0 + 12'($urandom_range(0, 15));
      endcase
      case ($urandom_range(0, 7))
        0:       d = 16'hFFFF;
        1:       d = 16'hFFFE;
        2:       d = 16'h0003;
        3:       d = 16'h8001;
        default: d = 16'($urandom);
      endcase
      wr  = !rst && ($urandom_range(0, 2) == 0);
      rd  = 1'($urandom_range(0, 1));
      hlt = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 3) == 0) port_in = 16'($urandom);
      cycle(rd, wr, a, d, hlt, rst);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
